// File: rtl/cpu_consts.sv
// Shared CPU constants and types used by the data memory.
package cpu_consts;

    localparam int unsigned DMEM_BYTES_DEFAULT = 512 * 1024;

    typedef enum logic {
        DMEM_IDLE,
        DMEM_BUSY
    } dmem_state_t;

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM: 64-bit words, byte write enables,
// registered read. The output register updates only on a read strobe,
// so it doubles as the read hold register.
module dmem_bram #(
  parameter int unsigned DEPTH     = 65536,
  parameter string       INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               we,
  input  logic                     re,
  input  logic [63:0]              din,
  output logic [63:0]              dout
);

  logic [63:0] mem [DEPTH];

  // Byte-lane writes and registered read
  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 8; n++) begin
      if (we[n]) begin
        mem[addr][n*8 +: 8] <= din[n*8 +: 8];
      end
    end
    if (re) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem.sv
// Data memory behind the load/store stage: accepts one request at a time,
// answers after a fixed per-direction latency, supports flush-abort.
module data_mem
    import cpu_consts::*;
#(
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WR_LATENCY = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [63:0] addr_i,
    input  logic        wr_i,
    input  logic [63:0] wr_data_i,
    input  logic [7:0]  mask_i,
    input  logic        flush_i,
    output logic        wr_done_o,
    output logic        rd_valid_o,
    output logic [63:0] rd_data_o,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int unsigned AW      = $clog2(DMEM_BYTES);
    localparam int unsigned DEPTH   = DMEM_BYTES / 8;
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LATENCY - 1);

    dmem_state_t state, state_next;
    logic [CW-1:0] cnt;
    logic          op_wr;
    logic          proto_err;
    logic          accept;
    logic          fire;
    logic [7:0]    ram_we;
    logic          ram_re;
    logic [63:0]   hold;

    // Address bits outside the doubleword index are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[63:AW], addr_i[2:0]};

    assign accept = (state == DMEM_IDLE) && req_i && !reset;
    assign ram_we = (accept && wr_i) ? mask_i : '0;
    assign ram_re = accept && !wr_i;

    dmem_bram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk  (clk),
        .addr (addr_i[AW-1:3]),
        .we   (ram_we),
        .re   (ram_re),
        .din  (wr_data_i),
        .dout (hold)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DMEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, leave BUSY on flush or counter expiry
    always_comb begin
        state_next = state;
        unique case (state)
            DMEM_IDLE: if (req_i)                   state_next = DMEM_BUSY;
            DMEM_BUSY: if (flush_i || cnt == '0)    state_next = DMEM_IDLE;
            default:                                state_next = DMEM_IDLE;
        endcase
    end

    // Latency counter, latched direction and sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= wr_i ? WR_LOAD : RD_LOAD;
                op_wr <= wr_i;
            end else if (state == DMEM_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == DMEM_BUSY && req_i && !flush_i) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Outputs: one-cycle response at counter expiry unless flushed
    always_comb begin
        busy_o      = (state == DMEM_BUSY);
        fire        = (state == DMEM_BUSY) && (cnt == '0) && !flush_i;
        wr_done_o   = fire && op_wr;
        rd_valid_o  = fire && !op_wr;
        rd_data_o   = rd_valid_o ? hold : '0;
        proto_err_o = proto_err;
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: three instances with different latencies
// share one stimulus stream; each phase resets and checks one instance.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [63:0] addr = '0;
    logic        wr = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  mask = '0;
    logic        flush = 1'b0;

    logic        wr_done  [3];
    logic        rd_valid [3];
    logic [63:0] rd_data  [3];
    logic        busy     [3];
    logic        perr     [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    data_mem u_dut0 (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .wr_i(wr),
        .wr_data_i(wdata), .mask_i(mask), .flush_i(flush),
        .wr_done_o(wr_done[0]), .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]),
        .busy_o(busy[0]), .proto_err_o(perr[0])
    );

    data_mem #(.DMEM_BYTES(4096), .RD_LATENCY(4), .WR_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .wr_i(wr),
        .wr_data_i(wdata), .mask_i(mask), .flush_i(flush),
        .wr_done_o(wr_done[1]), .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]),
        .busy_o(busy[1]), .proto_err_o(perr[1])
    );

    data_mem #(.DMEM_BYTES(4096), .RD_LATENCY(3), .WR_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .wr_i(wr),
        .wr_data_i(wdata), .mask_i(mask), .flush_i(flush),
        .wr_done_o(wr_done[2]), .rd_valid_o(rd_valid[2]), .rd_data_o(rd_data[2]),
        .busy_o(busy[2]), .proto_err_o(perr[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] m);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        mask  = m;
    endtask

    task automatic do_reset();
        req = 1'b0; flush = 1'b0; reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Follows a request issued this cycle for lat+1 cycles; the response
    // pulse must appear exactly lat cycles after acceptance.
    task automatic watch(input int d, input int lat, input logic is_wr,
                         input logic [63:0] exp_data, input string tag);
        for (int i = 1; i <= lat + 1; i++) begin
            tick();
            req = 1'b0; flush = 1'b0;
            #1;
            chk({tag, "_pulse"}, {62'd0, wr_done[d], rd_valid[d]},
                (i == lat) ? (is_wr ? 64'd2 : 64'd1) : 64'd0);
            chk({tag, "_busy"}, {63'd0, busy[d]}, (i <= lat) ? 64'd1 : 64'd0);
            chk({tag, "_data"}, rd_data[d], (!is_wr && i == lat) ? exp_data : 64'd0);
        end
    endtask

    initial begin
        // Reset held 3 cycles, then 10 idle cycles with all outputs low
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("reset_idle", {rd_data[0], wr_done[0], rd_valid[0], busy[0], perr[0]} == '0,
                64'd1);
        end

        // Default latencies: full write, masked write, read-back
        issue(1'b1, 64'h100, 64'h1122334455667788, 8'hFF);
        watch(0, 1, 1'b1, '0, "wr_full");
        issue(1'b1, 64'h100, 64'h00000000AABB0000, 8'h0C);
        watch(0, 1, 1'b1, '0, "wr_mask");
        issue(1'b0, 64'h100, '0, '0);
        watch(0, 1, 1'b0, 64'h11223344AABB7788, "rd_merge");

        // Empty mask: done pulse, contents untouched
        issue(1'b1, 64'h100, '1, 8'h00);
        watch(0, 1, 1'b1, '0, "wr_nomask");
        issue(1'b0, 64'h100, '0, '0);
        watch(0, 1, 1'b0, 64'h11223344AABB7788, "rd_nomask");

        // Flush in the very cycle the counter is zero suppresses the pulse
        issue(1'b0, 64'h100, '0, '0);
        tick();
        req = 1'b0; flush = 1'b1;
        #1;
        chk("flush_cnt0_valid", {63'd0, rd_valid[0]}, 64'd0);
        chk("flush_cnt0_data", rd_data[0], 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_cnt0_idle", {62'd0, busy[0], rd_valid[0]}, 64'd0);
        chk("perr_dut0", {63'd0, perr[0]}, 64'd0);

        // Latency sweep RD=4 WR=3
        do_reset();
        issue(1'b1, 64'h8, 64'hDEADBEEFCAFEF00D, 8'hFF);
        watch(1, 3, 1'b1, '0, "lat_wr3");
        issue(1'b0, 64'h8, '0, '0);
        watch(1, 4, 1'b0, 64'hDEADBEEFCAFEF00D, "lat_rd4");
        chk("perr_dut1", {63'd0, perr[1]}, 64'd0);

        // Flush abort with immediate reissue, RD=3
        do_reset();
        issue(1'b1, 64'h48, 64'h0123456789ABCDEF, 8'hFF);
        watch(2, 2, 1'b1, '0, "pre_wr48");
        issue(1'b0, 64'h40, '0, '0);
        tick();
        req = 1'b0; flush = 1'b1;
        #1;
        chk("abort_t1_valid", {63'd0, rd_valid[2]}, 64'd0);
        chk("abort_t1_busy", {63'd0, busy[2]}, 64'd1);
        tick();
        flush = 1'b0;
        issue(1'b0, 64'h48, '0, '0);
        #1;
        chk("abort_t2_idle", {62'd0, busy[2], rd_valid[2]}, 64'd0);
        watch(2, 3, 1'b0, 64'h0123456789ABCDEF, "reissue");
        chk("abort_perr", {63'd0, perr[2]}, 64'd0);

        // Flushed write still commits, WR=2
        issue(1'b1, 64'h10, '1, 8'hFF);
        watch(2, 2, 1'b1, '0, "pre_wr10");
        issue(1'b1, 64'h10, 64'h55, 8'h01);
        tick();
        req = 1'b0; flush = 1'b1;
        #1;
        chk("fwr_t1_done", {63'd0, wr_done[2]}, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fwr_t2_done", {62'd0, busy[2], wr_done[2]}, 64'd0);
        tick();
        #1;
        chk("fwr_t3_done", {63'd0, wr_done[2]}, 64'd0);
        issue(1'b0, 64'h10, '0, '0);
        watch(2, 3, 1'b0, 64'hFFFFFFFFFFFFFF55, "fwr_read");

        // Protocol violation: second request while BUSY is dropped
        do_reset();
        issue(1'b1, 64'h0, 64'h0F0E0D0C0B0A0908, 8'hFF);
        watch(2, 2, 1'b1, '0, "pre_wr0");
        issue(1'b0, 64'h0, '0, '0);
        tick();
        issue(1'b0, 64'h8, '0, '0);
        #1;
        chk("perr_t1", {62'd0, perr[2], rd_valid[2]}, 64'd0);
        tick();
        req = 1'b0;
        #1;
        chk("perr_t2", {62'd0, perr[2], rd_valid[2]}, 64'd2);
        tick();
        #1;
        chk("perr_t3_valid", {62'd0, perr[2], rd_valid[2]}, 64'd3);
        chk("perr_t3_data", rd_data[2], 64'h0F0E0D0C0B0A0908);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("perr_after", {61'd0, perr[2], busy[2], rd_valid[2]}, 64'd4);
        end
        do_reset();
        #1;
        chk("perr_cleared", {63'd0, perr[2]}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
